// File: rtl/wb_queue.sv
// Multi-lane write-back queue: merges NUM_SRC lanes into one register-file write per cycle,
// with zero-latency bypass when empty. Optional forwarding lookup enabled by macro WB_FORWARD_EN.
module wb_queue #(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_SRC-1:0]                 is_valid_i,
   input  logic [NUM_SRC-1:0]                 reg_file_write_en_i,
   input  logic [NUM_SRC-1:0][1:0]            reg_data_ctrl_sig_i,
   input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] reg_dest_addr_i,
   input  logic [NUM_SRC-1:0][WORD-1:0]       alu_result_i,
   input  logic [NUM_SRC-1:0][WORD-1:0]       mem_data_i,
   output logic                               ready_o,
   output logic                               reg_file_write_en_o,
   output logic [ADDR_WIDTH-1:0]              reg_dest_addr_o,
   output logic [WORD-1:0]                    reg_data_o,
   output logic [$clog2(DEPTH):0]             count_o,
   input  logic [ADDR_WIDTH-1:0]              fwd_addr_i,
   output logic                               fwd_hit_o,
   output logic [WORD-1:0]                    fwd_data_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int LW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [1:0] FROM_ALU    = 2'd0;
   localparam logic [1:0] FROM_MEMORY = 2'd1;

   logic [PW-1:0]         rptr_q, rptr_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
   logic [WORD-1:0]       data_mem_q [DEPTH];

   logic [NUM_SRC-1:0]         acc_s;
   logic [NUM_SRC-1:0]         enq_s;
   logic [NUM_SRC-1:0][PW-1:0] enq_pos_s;
   logic [CW-1:0]              enq_cnt_s;
   logic                       bypass_s;
   logic [LW-1:0]              byp_lane_s;
   logic                       deq_s;

   function automatic logic [WORD-1:0] lane_data(input logic [1:0]      sel,
                                                 input logic [WORD-1:0] alu,
                                                 input logic [WORD-1:0] mem);
      case (sel)
         FROM_ALU:    lane_data = alu;
         FROM_MEMORY: lane_data = mem;
         default:     lane_data = {WORD{1'bx}};
      endcase
   endfunction

   assign count_o = count_q;

   // Space for a full set of lanes; depends on state only.
   always_comb begin
      ready_o = (DEPTH - int'(count_q)) >= NUM_SRC;
   end

   always_comb begin
      acc_s = {NUM_SRC{1'b0}};
      if (!rst_i && ready_o) begin
         acc_s = is_valid_i & reg_file_write_en_i;
      end else begin
         acc_s = {NUM_SRC{1'b0}};
      end
   end

   // Bypass lane selection, enqueue slot assignment and pointer/count next state.
   always_comb begin
      bypass_s   = 1'b0;
      byp_lane_s = {LW{1'b0}};
      enq_s      = {NUM_SRC{1'b0}};
      enq_pos_s  = '0;
      enq_cnt_s  = {CW{1'b0}};
      for (int k = 0; k < NUM_SRC; k++) begin
         if (acc_s[k] && !bypass_s && (count_q == {CW{1'b0}})) begin
            bypass_s   = 1'b1;
            byp_lane_s = LW'(k);
         end else begin
            bypass_s   = bypass_s;
         end
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         if (acc_s[k] && !(bypass_s && (byp_lane_s == LW'(k)))) begin
            enq_s[k]     = 1'b1;
            enq_pos_s[k] = wptr_q + PW'(enq_cnt_s);
            enq_cnt_s    = enq_cnt_s + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            enq_s[k]     = 1'b0;
         end
      end
      deq_s   = !rst_i && (count_q != {CW{1'b0}});
      count_d = count_q + enq_cnt_s - {{(CW-1){1'b0}}, deq_s};
      wptr_d  = wptr_q + PW'(enq_cnt_s);
      rptr_d  = rptr_q + {{(PW-1){1'b0}}, deq_s};
   end

   // Write port: head entry when queued, otherwise the bypassed lane.
   always_comb begin
      reg_file_write_en_o = 1'b0;
      reg_dest_addr_o     = {ADDR_WIDTH{1'b0}};
      reg_data_o          = {WORD{1'b0}};
      if (rst_i) begin
         reg_file_write_en_o = 1'b0;
      end else if (count_q != {CW{1'b0}}) begin
         reg_file_write_en_o = 1'b1;
         reg_dest_addr_o     = addr_mem_q[rptr_q];
         reg_data_o          = data_mem_q[rptr_q];
      end else if (bypass_s) begin
         reg_file_write_en_o = 1'b1;
         reg_dest_addr_o     = reg_dest_addr_i[byp_lane_s];
         reg_data_o          = lane_data(reg_data_ctrl_sig_i[byp_lane_s],
                                         alu_result_i[byp_lane_s], mem_data_i[byp_lane_s]);
      end else begin
         reg_file_write_en_o = 1'b0;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q  <= {PW{1'b0}};
         wptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage is left uninitialised by reset; occupancy alone defines validity.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NUM_SRC; k++) begin
         if (enq_s[k]) begin
            addr_mem_q[enq_pos_s[k]] <= reg_dest_addr_i[k];
            data_mem_q[enq_pos_s[k]] <= lane_data(reg_data_ctrl_sig_i[k], alu_result_i[k], mem_data_i[k]);
         end
      end
   end

`ifdef WB_FORWARD_EN
   // Youngest match wins: queue oldest->newest, then accepted lanes in ascending order.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = {WORD{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (addr_mem_q[rptr_q + PW'(i)] == fwd_addr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = data_mem_q[rptr_q + PW'(i)];
         end else begin
            fwd_hit_o  = fwd_hit_o;
         end
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         if (acc_s[k] && (reg_dest_addr_i[k] == fwd_addr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = lane_data(reg_data_ctrl_sig_i[k], alu_result_i[k], mem_data_i[k]);
         end else begin
            fwd_hit_o  = fwd_hit_o;
         end
      end
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^fwd_addr_i;
   assign fwd_hit_o    = 1'b0;
   assign fwd_data_o   = {WORD{1'b0}};
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model plus directed literal scenarios.
module tb_wb_queue;
   localparam int WORD  = 32;
   localparam int AW    = 4;
   localparam int NSRC  = 2;
   localparam int DEPTH = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                       rst_i;
   logic [NSRC-1:0]            is_valid_i;
   logic [NSRC-1:0]            reg_file_write_en_i;
   logic [NSRC-1:0][1:0]       reg_data_ctrl_sig_i;
   logic [NSRC-1:0][AW-1:0]    reg_dest_addr_i;
   logic [NSRC-1:0][WORD-1:0]  alu_result_i;
   logic [NSRC-1:0][WORD-1:0]  mem_data_i;
   logic                       ready_o;
   logic                       reg_file_write_en_o;
   logic [AW-1:0]              reg_dest_addr_o;
   logic [WORD-1:0]            reg_data_o;
   logic [$clog2(DEPTH):0]     count_o;
   logic [AW-1:0]              fwd_addr_i;
   logic                       fwd_hit_o;
   logic [WORD-1:0]            fwd_data_o;

   wb_queue #(.WORD(WORD), .ADDR_WIDTH(AW), .NUM_SRC(NSRC), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .is_valid_i(is_valid_i), .reg_file_write_en_i(reg_file_write_en_i),
      .reg_data_ctrl_sig_i(reg_data_ctrl_sig_i), .reg_dest_addr_i(reg_dest_addr_i),
      .alu_result_i(alu_result_i), .mem_data_i(mem_data_i),
      .ready_o(ready_o), .reg_file_write_en_o(reg_file_write_en_o),
      .reg_dest_addr_o(reg_dest_addr_o), .reg_data_o(reg_data_o), .count_o(count_o),
      .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: pending writes in arrival order.
   logic [AW-1:0]   mq_a [$];
   logic [WORD-1:0] mq_d [$];
   logic [AW-1:0]   wlog [$];

   logic            obs_wr, obs_ready, obs_hit;
   logic [AW-1:0]   obs_addr;
   logic [WORD-1:0] obs_data, obs_fd;
   logic [31:0]     obs_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_lane(input int k, input logic v, input logic w, input logic [1:0] s,
                           input logic [AW-1:0] a, input logic [WORD-1:0] alu, input logic [WORD-1:0] mem);
      is_valid_i[k]          = v;
      reg_file_write_en_i[k] = w;
      reg_data_ctrl_sig_i[k] = s;
      reg_dest_addr_i[k]     = a;
      alu_result_i[k]        = alu;
      mem_data_i[k]          = mem;
   endtask

   task automatic idle();
      for (int k = 0; k < NSRC; k++) set_lane(k, 1'b0, 1'b0, 2'd0, '0, '0, '0);
   endtask

   // One cycle: inputs are already set; compare against the model, then advance both.
   task automatic run_cycle(input logic r);
      logic [AW-1:0]   la [$];
      logic [WORD-1:0] ld [$];
      logic            exp_ready, exp_wr, exp_hit;
      logic [AW-1:0]   exp_addr;
      logic [WORD-1:0] exp_data, exp_fd;
      rst_i = r;
      #1;
      la = mq_a;
      ld = mq_d;
      exp_ready = (DEPTH - mq_a.size()) >= NSRC;
      if (!r && exp_ready) begin
         for (int k = 0; k < NSRC; k++) begin
            if (is_valid_i[k] && reg_file_write_en_i[k]) begin
               la.push_back(reg_dest_addr_i[k]);
               ld.push_back((reg_data_ctrl_sig_i[k] == 2'd0) ? alu_result_i[k] : mem_data_i[k]);
            end
         end
      end
      exp_wr   = !r && (la.size() > 0);
      exp_addr = exp_wr ? la[0] : '0;
      exp_data = exp_wr ? ld[0] : '0;
      exp_hit  = 1'b0;
      exp_fd   = '0;
`ifdef WB_FORWARD_EN
      for (int i = 0; i < la.size(); i++) begin
         if (la[i] == fwd_addr_i) begin
            exp_hit = 1'b1;
            exp_fd  = ld[i];
         end
      end
`endif
      obs_wr = reg_file_write_en_o; obs_addr = reg_dest_addr_o; obs_data = reg_data_o;
      obs_cnt = 32'(count_o); obs_ready = ready_o; obs_hit = fwd_hit_o; obs_fd = fwd_data_o;
      chk("wr_en", 32'(obs_wr), 32'(exp_wr));
      chk("addr", 32'(obs_addr), 32'(exp_addr));
      chk("data", obs_data, exp_data);
      chk("count", obs_cnt, 32'(mq_a.size()));
      chk("ready", 32'(obs_ready), 32'(exp_ready));
      chk("fwd_hit", 32'(obs_hit), 32'(exp_hit));
      chk("fwd_data", obs_fd, exp_fd);
      if (obs_wr) wlog.push_back(obs_addr);
      if (r) begin
         mq_a.delete();
         mq_d.delete();
      end else begin
         if (la.size() > 0) begin
            void'(la.pop_front());
            void'(ld.pop_front());
         end
         mq_a = la;
         mq_d = ld;
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      idle();
      fwd_addr_i = '0;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);

      // Reset cycle with lanes presented: dropped, no write.
      set_lane(0, 1'b1, 1'b1, 2'd0, 4'd9, 32'h99, 32'h0);
      run_cycle(1'b1);
      chk("rst_wr", 32'(obs_wr), 32'd0);
      chk("rst_ready", 32'(obs_ready), 32'd1);

      // Single lane bypass.
      idle();
      set_lane(0, 1'b1, 1'b1, 2'd0, 4'd3, 32'hAAAA0001, 32'h0);
      run_cycle(1'b0);
      chk("byp_addr", 32'(obs_addr), 32'd3);
      chk("byp_data", obs_data, 32'hAAAA0001);
      chk("byp_count", obs_cnt, 32'd0);
      idle();
      run_cycle(1'b0);
      chk("byp_count_next", obs_cnt, 32'd0);

      // Two lanes in one cycle.
      set_lane(0, 1'b1, 1'b1, 2'd0, 4'd1, 32'h11, 32'hDEAD);
      set_lane(1, 1'b1, 1'b1, 2'd1, 4'd2, 32'hBEEF, 32'h22);
      run_cycle(1'b0);
      chk("two_n_addr", 32'(obs_addr), 32'd1);
      chk("two_n_data", obs_data, 32'h11);
      idle();
      run_cycle(1'b0);
      chk("two_n1_addr", 32'(obs_addr), 32'd2);
      chk("two_n1_data", obs_data, 32'h22);
      chk("two_n1_count", obs_cnt, 32'd1);
      run_cycle(1'b0);
      chk("two_n2_count", obs_cnt, 32'd0);
      chk("two_n2_wr", 32'(obs_wr), 32'd0);

      // Valid without write request.
      set_lane(0, 1'b1, 1'b0, 2'd0, 4'd4, 32'h4, 32'h0);
      set_lane(1, 1'b1, 1'b0, 2'd0, 4'd5, 32'h5, 32'h0);
      run_cycle(1'b0);
      chk("nowe_wr", 32'(obs_wr), 32'd0);
      idle();
      run_cycle(1'b0);
      chk("nowe_count", obs_cnt, 32'd0);

      // Back-pressure: three full cycles, then inputs while not ready.
      wlog.delete();
      for (int c = 0; c < 3; c++) begin
         set_lane(0, 1'b1, 1'b1, 2'd0, AW'(2*c+1), 32'h100 + 32'(c), 32'h0);
         set_lane(1, 1'b1, 1'b1, 2'd1, AW'(2*c+2), 32'h0, 32'h200 + 32'(c));
         run_cycle(1'b0);
      end
      set_lane(0, 1'b1, 1'b1, 2'd0, 4'd7, 32'h7, 32'h0);
      set_lane(1, 1'b1, 1'b1, 2'd0, 4'd8, 32'h8, 32'h0);
      run_cycle(1'b0);
      chk("bp_ready", 32'(obs_ready), 32'd0);
      chk("bp_count", obs_cnt, 32'd3);
      idle();
      repeat (3) run_cycle(1'b0);
      chk("bp_drained", 32'(obs_wr), 32'd0);
      chk("bp_len", 32'(wlog.size()), 32'd6);
      for (int i = 0; i < wlog.size(); i++) chk("bp_order", 32'(wlog[i]), 32'(i + 1));

      // Forwarding: queued addr 5 = 0x50, then lane 1 addr 5 = 0x51.
      set_lane(0, 1'b1, 1'b1, 2'd0, 4'd4, 32'h40, 32'h0);
      set_lane(1, 1'b1, 1'b1, 2'd0, 4'd5, 32'h50, 32'h0);
      run_cycle(1'b0);
      idle();
      set_lane(1, 1'b1, 1'b1, 2'd0, 4'd5, 32'h51, 32'h0);
      fwd_addr_i = 4'd5;
      run_cycle(1'b0);
`ifdef WB_FORWARD_EN
      chk("fwd_hit_lit", 32'(obs_hit), 32'd1);
      chk("fwd_data_lit", obs_fd, 32'h51);
`else
      chk("fwd_hit_lit", 32'(obs_hit), 32'd0);
`endif
      idle();
      repeat (2) run_cycle(1'b0);

      // Reset while holding three entries.
      for (int c = 0; c < 3; c++) begin
         set_lane(0, 1'b1, 1'b1, 2'd0, 4'hA, 32'hA0 + 32'(c), 32'h0);
         set_lane(1, 1'b1, 1'b1, 2'd0, 4'hB, 32'hB0 + 32'(c), 32'h0);
         run_cycle(1'b0);
      end
      chk("pre_rst_count", 32'(count_o), 32'd3);
      run_cycle(1'b1);
      idle();
      run_cycle(1'b0);
      chk("post_rst_wr", 32'(obs_wr), 32'd0);
      chk("post_rst_count", obs_cnt, 32'd0);
      chk("post_rst_ready", 32'(obs_ready), 32'd1);

      // Randomised traffic with occasional reset.
      for (int n = 0; n < 500; n++) begin
         for (int k = 0; k < NSRC; k++) begin
            set_lane(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     2'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, $urandom);
         end
         fwd_addr_i = AW'($urandom_range(0, 15));
         run_cycle($urandom_range(0, 39) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
